ir_array_sampler: RTL
=====================

// Module: ir_array_sampler
// PURPOSE
//  Parametrised IR line-sensor sequencer.
//  - Periodically powers the IR emitters, waits a settle time, then converts NUM_CH A2D channels in order.
//  - Stores each result, tracks the maximum reading and its channel index, and flags line presence
//    against a runtime threshold.
//  - Drives the A2D_intf conversion handshake externally; feeds the line-follow/maze control logic.
// PARAMETERS
//  NUM_CH      8     channels per round, 2..16 (ch 0..NUM_CH-1)
//  RES_W       12    A2D result width
//  CH_W        4     channel index width, must be >= $clog2(NUM_CH)
//  SETTLE_CYC  4096  cycles from IR_en rise to first strt_cnv
//  FAST_SIM    0     1: round period 2^14 clks, settle fixed at 2048; 0: 2^18 clks, SETTLE_CYC
// PORTS
//  clk           in   1            system clock
//  rst_n         in   1            async active-low reset
//  strt_cnv      out  1            1-cycle pulse, starts A2D conversion of chnnl
//  chnnl         out  CH_W         channel under conversion
//  cnv_cmplt     in   1            A2D done, res valid this cycle
//  res           in   RES_W        A2D result
//  thres         in   RES_W        line-present threshold, sampled in DONE
//  IR_en         out  1            emitter enable, high for the whole active round
//  IR_vld        out  1            1-cycle pulse, round results updated
//  line_present  out  1            ir_max > thres, registered at end of round
//  ir_data       out  NUM_CH*RES_W channel k at [k*RES_W +: RES_W]
//  ir_max        out  RES_W        largest reading of the last round
//  max_idx       out  CH_W         channel holding ir_max
// BEHAVIOUR
//  Reset:
//  - All outputs are 0, state is IDLE, and the round timer is 0.
//  - Reset asserted mid-round aborts the round immediately; no partial IR_vld is issued.
//  Round timer:
//  - Free-running counter; a round starts when the counter reaches all-ones and state is IDLE.
//  - A wrap during an active round is ignored; the round is never restarted.
//  FSM, one clock per arrow unless noted:
//  - IDLE: wait for round start -> SETTLE. On entry clear chnnl, the running max and the running index.
//  - SETTLE: IR_en=1, count SETTLE_CYC cycles -> STRT.
//  - STRT: strt_cnv=1 for one cycle -> WAIT.
//  - WAIT: on cnv_cmplt, store res into slot chnnl and update the running max.
//    - If chnnl==NUM_CH-1 -> DONE; else chnnl+1 -> STRT.
//  - DONE: drop IR_en, pulse IR_vld, copy running max/index to ir_max/max_idx,
//    set line_present=(ir_max_next > thres), then -> IDLE.
//  Conversion rules:
//  - cnv_cmplt outside WAIT is ignored.
//  - IR_en is high from the SETTLE entry clock through the last WAIT clock, inclusive.
//  - Max update uses strict > only: ties keep the lower index; all-zero readings give max_idx=0.
//  - line_present uses strict >: res==thres gives 0.
//  Result visibility:
//  - ir_data slots update as each channel completes.
//  - ir_max, max_idx and line_present change only in DONE.
//  - Latency from round start to IR_vld = SETTLE_CYC + sum over channels of (1 + A2D time) + 1.
// CONFIGURATION
//  Macro IR_OVERSMPL_EN defined:
//  - Each channel is converted 4 times back-to-back (STRT/WAIT x4, chnnl held).
//  - Results accumulate in a RES_W+2 accumulator; the stored value is acc>>2, truncated.
//  - The max compare uses the averaged value.
//  Macro undefined: one conversion per channel; no accumulator is built.
// STRUCTURE
//  - Package ir_pkg holds ir_state_t {IDLE,SETTLE,STRT,WAIT,DONE}, the round-period widths and the
//    FAST_SIM settle constant.
//  - Sub-module ir_max_track (running max/index with clr/upd/strict-greater compare) is instantiated
//    once; everything else stays inline.
// TESTING
//  1. Fixed A2D model, 20-clk conversions, res=16*(ch+1): one IR_vld per round;
//     ir_data slot k = 16*(k+1); ir_max=0x080; max_idx=7.
//  2. res=0x140 on ch2 and ch5, others 0x010, thres=0x13F: max_idx=2, line_present=1.
//     Same data with thres=0x140: line_present=0.
//  3. Stray cnv_cmplt pulses in IDLE and SETTLE: no ir_data change and no extra IR_vld.
//  4. rst_n low during ch4 WAIT: all outputs 0 within the reset; the next round runs cleanly from ch0.
//  5. FAST_SIM=1: two IR_vld pulses exactly 16384 clks apart.
//     IR_en high from round start to the cycle before IR_vld.
//  6. IR_OVERSMPL_EN, ch0 returns 0x100,0x101,0x102,0x104: exactly 4 strt_cnv pulses for ch0;
//     stored value 0x101.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared state encoding and timing constants for the IR line-sensor sampler.
package ir_pkg;

   typedef logic [2:0] ir_state_t;

   localparam ir_state_t IDLE   = 3'd0;
   localparam ir_state_t SETTLE = 3'd1;
   localparam ir_state_t STRT   = 3'd2;
   localparam ir_state_t WAIT   = 3'd3;
   localparam ir_state_t DONE   = 3'd4;

   // Round period is 2^PER_W clocks
   localparam int unsigned PER_W_FAST = 14;
   localparam int unsigned PER_W_SLOW = 18;

   // Emitter settle time used when FAST_SIM is set
   localparam int unsigned FAST_SETTLE_CYC = 2048;

endpackage

// File: rtl/ir_max_track.sv
// Running maximum / index tracker. Strict greater-than compare, so ties keep
// the earlier (lower) channel and an all-zero round leaves index 0.
module ir_max_track
   import ir_pkg::*;
#(
   parameter int unsigned RES_W = 12,
   parameter int unsigned CH_W  = 4
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             upd,
   input  logic [RES_W-1:0] val,
   input  logic [CH_W-1:0]  idx,
   output logic [RES_W-1:0] max_nxt_c,
   output logic [CH_W-1:0]  idx_nxt_c
);

   logic [RES_W-1:0] max_q;
   logic [CH_W-1:0]  idx_q;

   // Next running max/index including this cycle's sample
   always_comb begin
      max_nxt_c = max_q;
      idx_nxt_c = idx_q;
      if (clr) begin
         max_nxt_c = '0;
         idx_nxt_c = '0;
      end else if (upd && (val > max_q)) begin
         max_nxt_c = val;
         idx_nxt_c = idx;
      end
   end

   // Running max/index registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_q <= '0;
         idx_q <= '0;
      end else begin
         max_q <= max_nxt_c;
         idx_q <= idx_nxt_c;
      end
   end

endmodule

// File: rtl/ir_array_sampler.sv
// IR line-sensor sequencer: powers emitters each round, waits for settle,
// converts every channel through the external A2D handshake, keeps per-channel
// results, the round maximum with its channel, and a line-present flag.
// Optional build macro: IR_OVERSMPL_EN (4 averaged conversions per channel).
module ir_array_sampler
   import ir_pkg::*;
#(
   parameter int unsigned NUM_CH     = 8,
   parameter int unsigned RES_W      = 12,
   parameter int unsigned CH_W       = 4,
   parameter int unsigned SETTLE_CYC = 4096,
   parameter bit          FAST_SIM   = 1'b0
)(
   input  logic                    clk,
   input  logic                    rst_n,
   output logic                    strt_cnv,
   output logic [CH_W-1:0]         chnnl,
   input  logic                    cnv_cmplt,
   input  logic [RES_W-1:0]        res,
   input  logic [RES_W-1:0]        thres,
   output logic                    IR_en,
   output logic                    IR_vld,
   output logic                    line_present,
   output logic [NUM_CH*RES_W-1:0] ir_data,
   output logic [RES_W-1:0]        ir_max,
   output logic [CH_W-1:0]         max_idx
);

   localparam int unsigned PER_W    = FAST_SIM ? PER_W_FAST : PER_W_SLOW;
   localparam int unsigned SETTLE_N = FAST_SIM ? FAST_SETTLE_CYC : SETTLE_CYC;
   localparam int unsigned SET_W    = $clog2(SETTLE_N + 1);
   localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_N - 1);

   ir_state_t        state;
   ir_state_t        nxt_state;
   logic [PER_W-1:0] round_tmr;
   logic [SET_W-1:0] settle_cnt;
   logic             round_start_c;
   logic             conv_done_c;
   logic             last_smp_c;
   logic             store_c;
   logic [RES_W-1:0] smp_c;
   logic [RES_W-1:0] max_nxt_c;
   logic [CH_W-1:0]  idx_nxt_c;

   assign round_start_c = (&round_tmr) && (state == IDLE);
   assign conv_done_c   = (state == WAIT) && cnv_cmplt;
   assign store_c       = conv_done_c && last_smp_c;

`ifdef IR_OVERSMPL_EN
   logic [1:0]       os_cnt;
   logic [RES_W+1:0] acc;
   logic [RES_W+1:0] acc_sum_c;

   assign acc_sum_c  = acc + (RES_W+2)'(res);
   assign last_smp_c = (os_cnt == 2'd3);
   assign smp_c      = acc_sum_c[RES_W+1:2];

   // Four back-to-back conversions per channel, summed then divided by 4
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         os_cnt <= '0;
         acc    <= '0;
      end else if (state == IDLE) begin
         os_cnt <= '0;
         acc    <= '0;
      end else if (conv_done_c) begin
         os_cnt <= os_cnt + 2'd1;
         acc    <= last_smp_c ? '0 : acc_sum_c;
      end
   end
`else
   assign last_smp_c = 1'b1;
   assign smp_c      = res;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt_state;
   end

   // Next-state logic
   always_comb begin
      nxt_state = state;
      case (state)
         IDLE:    if (round_start_c) nxt_state = SETTLE;
         SETTLE:  if (settle_cnt == SET_LAST) nxt_state = STRT;
         STRT:    nxt_state = WAIT;
         WAIT: begin
            if (conv_done_c) begin
               if (last_smp_c && (chnnl == LAST_CH)) nxt_state = DONE;
               else                                  nxt_state = STRT;
            end
         end
         DONE:    nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   // Round timer, settle counter, channel pointer and handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         round_tmr  <= '0;
         settle_cnt <= '0;
         chnnl      <= '0;
         strt_cnv   <= 1'b0;
         IR_en      <= 1'b0;
         IR_vld     <= 1'b0;
      end else begin
         round_tmr  <= round_tmr + PER_W'(1);
         settle_cnt <= (state == SETTLE) ? settle_cnt + SET_W'(1) : '0;
         strt_cnv   <= (nxt_state == STRT);
         IR_en      <= (nxt_state == SETTLE) || (nxt_state == STRT) || (nxt_state == WAIT);
         IR_vld     <= (nxt_state == DONE);
         if (state == IDLE)
            chnnl <= '0;
         else if (store_c && (chnnl != LAST_CH))
            chnnl <= chnnl + CH_W'(1);
      end
   end

   ir_max_track #(
      .RES_W (RES_W),
      .CH_W  (CH_W)
   ) u_max (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (state == IDLE),
      .upd       (store_c),
      .val       (smp_c),
      .idx       (chnnl),
      .max_nxt_c (max_nxt_c),
      .idx_nxt_c (idx_nxt_c)
   );

   // Per-channel result slots and end-of-round summary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_data      <= '0;
         ir_max       <= '0;
         max_idx      <= '0;
         line_present <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (store_c && (chnnl == CH_W'(k)))
               ir_data[k*RES_W +: RES_W] <= smp_c;
         end
         if (nxt_state == DONE) begin
            ir_max       <= max_nxt_c;
            max_idx      <= idx_nxt_c;
            line_present <= (max_nxt_c > thres);
         end
      end
   end

endmodule
